rr_arbiter_eight: RTL

Eight-way round-robin arbiter that shares one downstream resource among eight requesters. It is the decoder's controller: it keeps a registered 3-bit grant index plus a valid bit, and drives a one-hot grant vector that is the 3-to-8 decode of that index, gated by the valid bit. A hold-time watchdog revokes grants that exceed a configured number of cycles. Release is by handshake (per-requester `done`) or by dropping the request.

---
 rtl/rr_arbiter_eight.sv | 106 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_eight.sv
// Eight-way round-robin arbiter with a registered grant index, one-hot grant decode,
// done/request-drop release and an optional hold-time watchdog.
module rr_arbiter_eight #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic       WD_EN     = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = WD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] idx_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic       to_nxt;

    logic [2:0] win;
    logic [2:0] cand;
    logic       win_found;
    logic       rel_done, rel_drop, rel_wd;

    // Search upward from ptr (inclusive), wrapping 7 -> 0 via 3-bit arithmetic.
    always_comb begin
        win       = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        rel_done = done[gnt_idx];
        rel_drop = !req[gnt_idx];
        rel_wd   = WD_EN && (hold_cnt == HOLD_LAST);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    idx_nxt   = win;
                    hold_nxt  = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (rel_done || rel_drop || rel_wd) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_idx + 3'd1;
                    // A handshake release on the expiry edge is not a revoke.
                    to_nxt    = rel_wd && !rel_done && !rel_drop;
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= idx_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= to_nxt;
        end
    end

    assign gnt_valid = (state == BUSY);

    always_comb begin
        gnt          = '0;
        gnt[gnt_idx] = gnt_valid;
    end

endmodule
